// File: rtl/clock_divider_ctrl.sv
// Run/stop controller and runtime-programmable clock divider with glitch-free
// divisor updates applied only at the falling edge of clk_out.
module clock_divider_ctrl #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 div_valid,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 div_ready,
  output logic                 cfg_err,
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] active_div
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_WAIT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] pend_div, pend_div_nxt;
  logic                 pend_valid, pend_valid_nxt;
  logic [DIV_WIDTH-1:0] active_div_nxt;
  logic                 clk_out_nxt, rise_nxt, fall_nxt, cfg_err_nxt;

  logic accept, acc_zero, acc_nz;
  logic term, stop_now, fall_edge, to_idle;

  assign accept    = div_valid && div_ready;
  assign acc_zero  = accept && (div_value == '0);
  assign acc_nz    = accept && (div_value != '0);
  assign term      = (cnt == active_div - DIV_ONE);
  // Low-phase stop in RUN leaves immediately; clk_out is already 0.
  assign stop_now  = (state == RUN) && !enable && !clk_out;
  assign fall_edge = (state != IDLE) && term && clk_out;
  assign to_idle   = (state != IDLE) && (state_nxt == IDLE);

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a fall toggle on the stop edge skips STOP_WAIT entirely
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable) begin
          if (!clk_out || term) state_nxt = IDLE;
          else                  state_nxt = STOP_WAIT;
        end
      end
      STOP_WAIT: if (term) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: counter, toggles, ticks and divisor bookkeeping
  always_comb begin
    cnt_nxt        = cnt;
    clk_out_nxt    = clk_out;
    rise_nxt       = 1'b0;
    fall_nxt       = 1'b0;
    cfg_err_nxt    = acc_zero;
    pend_valid_nxt = pend_valid;
    pend_div_nxt   = pend_div;
    active_div_nxt = active_div;

    if (state == IDLE) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      if (acc_nz) active_div_nxt = div_value;
    end else if (stop_now) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      if (pend_valid) begin
        active_div_nxt = pend_div;
        pend_valid_nxt = 1'b0;
      end else if (acc_nz) begin
        active_div_nxt = div_value;
      end
    end else begin
      if (term) begin
        cnt_nxt     = '0;
        clk_out_nxt = !clk_out;
        rise_nxt    = !clk_out;
        fall_nxt    = clk_out;
      end else begin
        cnt_nxt = cnt + DIV_ONE;
      end
      if (fall_edge && pend_valid) begin
        active_div_nxt = pend_div;
        pend_valid_nxt = 1'b0;
      end
      // A value landing on the edge into IDLE is applied directly so IDLE never holds a pending divisor
      if (acc_nz) begin
        if (to_idle) begin
          active_div_nxt = div_value;
        end else begin
          pend_div_nxt   = div_value;
          pend_valid_nxt = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      cfg_err    <= 1'b0;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      active_div <= DIV_RESET;
      div_ready  <= 1'b1;
      running    <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      clk_out    <= clk_out_nxt;
      rise_tick  <= rise_nxt;
      fall_tick  <= fall_nxt;
      cfg_err    <= cfg_err_nxt;
      pend_valid <= pend_valid_nxt;
      pend_div   <= pend_div_nxt;
      active_div <= active_div_nxt;
      div_ready  <= !pend_valid_nxt;
      running    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: directed scenarios plus random stimulus against a
// phase-level model that tracks cycles remaining in the current clk_out phase.
module tb_clock_divider_ctrl;
  localparam int unsigned DW = 16;

  logic          clk_in;
  logic          reset;
  logic          enable;
  logic          div_valid;
  logic [DW-1:0] div_value;
  logic          div_ready;
  logic          cfg_err;
  logic          clk_out;
  logic          rise_tick;
  logic          fall_tick;
  logic          running;
  logic [DW-1:0] active_div;

  clock_divider_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(5)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .div_valid  (div_valid),
    .div_value  (div_value),
    .div_ready  (div_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .running    (running),
    .active_div (active_div)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: 0=idle 1=run 2=stopping; m_rem = edges left until the next toggle
  int m_state;
  bit m_out, m_rise, m_fall, m_err;
  int m_rem;
  int m_div;
  int m_pend[$];

  function automatic void model_reset();
    m_state = 0; m_out = 0; m_rise = 0; m_fall = 0; m_err = 0;
    m_rem = 0; m_div = 5; m_pend.delete();
  endfunction

  function automatic void model_step(bit en, bit dv, int val);
    bit ready, acc, nz;
    ready  = (m_pend.size() == 0);
    acc    = dv && ready;
    m_err  = acc && (val == 0);
    nz     = acc && (val != 0);
    m_rise = 0;
    m_fall = 0;
    if (m_state == 0) begin
      if (nz) m_div = val;
      if (en) begin
        m_state = 1;
        m_rem   = m_div;
      end
    end else if (m_state == 1 && !en && !m_out) begin
      m_state = 0;
      if (m_pend.size() != 0) m_div = m_pend.pop_front();
      else if (nz) m_div = val;
    end else begin
      if (m_state == 1 && !en) m_state = 2;
      m_rem--;
      if (m_rem == 0) begin
        if (m_out) begin
          m_out  = 0;
          m_fall = 1;
          if (m_pend.size() != 0) m_div = m_pend.pop_front();
          if (m_state == 2) begin
            m_state = 0;
            if (nz) begin
              m_div = val;
              nz    = 0;
            end
          end
        end else begin
          m_out  = 1;
          m_rise = 1;
        end
        m_rem = m_div;
      end
      if (nz) m_pend.push_back(val);
    end
  endfunction

  task automatic compare_all();
    check("clk_out",    32'(clk_out),    32'(m_out));
    check("rise_tick",  32'(rise_tick),  32'(m_rise));
    check("fall_tick",  32'(fall_tick),  32'(m_fall));
    check("cfg_err",    32'(cfg_err),    32'(m_err));
    check("running",    32'(running),    32'(m_state != 0));
    check("div_ready",  32'(div_ready),  32'(m_pend.size() == 0));
    check("active_div", 32'(active_div), 32'(m_div));
  endtask

  task automatic cycle(input bit en, input bit dv, input int val);
    enable    = en;
    div_valid = dv;
    div_value = DW'(val);
    @(posedge clk_in);
    model_step(en, dv, val);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  initial begin
    int first_rise, first_fall, highs, k, r0, r1;
    enable = 0; div_valid = 0; div_value = '0;
    reset = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk_in);
    reset = 1'b1;

    // Default divisor: first rise 5 after start, first fall 10 after start
    first_rise = -1; first_fall = -1;
    cycle(1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      cycle(1, 0, 0);
      if (rise_tick && first_rise < 0) first_rise = i;
      if (fall_tick && first_fall < 0) first_fall = i;
    end
    check("t1_first_rise", 32'(first_rise), 32'd5);
    check("t1_first_fall", 32'(first_fall), 32'd10);

    // Zero divisor is consumed with a single error pulse
    cycle(1, 1, 0);
    check("t3_err", 32'(cfg_err), 32'd1);
    check("t3_div", 32'(active_div), 32'd5);
    check("t3_ready", 32'(div_ready), 32'd1);
    cycle(1, 0, 0);
    check("t3_err_clear", 32'(cfg_err), 32'd0);

    // Mid-high update to 3: held pending until the next fall
    k = 0;
    while (!(m_out && m_rem == 3) && k < 40) begin cycle(1, 0, 0); k++; end
    if (k >= 40) check("t2_timeout", 32'd0, 32'd1);
    cycle(1, 1, 3);
    check("t2_ready_low", 32'(div_ready), 32'd0);
    for (int i = 0; i < 40; i++) cycle(1, 0, 0);
    check("t2_active", 32'(active_div), 32'd3);

    // Restore divisor 5, then drop enable at cnt=1 of a high phase
    cycle(1, 1, 5);
    k = 0;
    while (!(m_pend.size() == 0 && m_div == 5 && m_out && m_rem == 4) && k < 60) begin
      cycle(1, 0, 0); k++;
    end
    if (k >= 60) check("t4_timeout", 32'd0, 32'd1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      if (clk_out) highs++;
      else break;
    end
    check("t4_high_cycles", 32'(highs), 32'd3);
    check("t4_fall_tick", 32'(fall_tick), 32'd1);
    check("t4_running", 32'(running), 32'd0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);

    // Reset while high with a divisor pending
    cycle(1, 0, 0);
    k = 0;
    while (!(m_out && m_rem == m_div) && k < 40) begin cycle(1, 0, 0); k++; end
    if (k >= 40) check("t5_timeout", 32'd0, 32'd1);
    cycle(1, 1, 2);
    check("t5_pre_clk", 32'(clk_out), 32'd1);
    check("t5_pre_ready", 32'(div_ready), 32'd0);
    do_reset();
    check("t5_clk", 32'(clk_out), 32'd0);
    check("t5_div", 32'(active_div), 32'd5);
    check("t5_ready", 32'(div_ready), 32'd1);
    check("t5_running", 32'(running), 32'd0);

    // Start and divisor 2 on the same edge: rises 4 apart
    cycle(0, 0, 0);
    cycle(1, 1, 2);
    r0 = -1; r1 = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 0, 0);
      if (rise_tick) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
    end
    check("t6_first_rise", 32'(r0), 32'd2);
    check("t6_period", 32'(r1 - r0), 32'd4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 99) < 85, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
